// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit lab CPU: opcodes, FSM state encoding,
// instruction field positions and the two sign-extension helpers.
package cpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  // Instruction layout: op[7:6] rs[5:4] rt[3:2] rd[1:0]; jump offset is [5:0]
  localparam int OP_HI   = 7;
  localparam int OP_LO   = 6;
  localparam int RS_HI   = 5;
  localparam int RS_LO   = 4;
  localparam int RT_HI   = 3;
  localparam int RT_LO   = 2;
  localparam int RD_HI   = 1;
  localparam int RD_LO   = 0;
  localparam int JOFF_HI = 5;

  function automatic logic [7:0] sext_imm(input logic [7:0] ir);
    return {{6{ir[RD_HI]}}, ir[RD_HI:RD_LO]};
  endfunction

  function automatic logic [7:0] sext_joff(input logic [7:0] ir);
    return {{2{ir[JOFF_HI]}}, ir[JOFF_HI:0]};
  endfunction

endpackage

// File: rtl/fetch_control_if.sv
// Bundle between the fetch/control stage and its neighbours: ROM port,
// register-file addressing, ALU/memory controls and the debug state.
interface fetch_control_if;
  logic [7:0] inst_addr;
  logic [7:0] inst_data;
  logic [1:0] read_register1;
  logic [1:0] read_register2;
  logic [1:0] destination_register;
  logic [7:0] imm_ext;
  logic       regdst;
  logic       alusrc;
  logic       memtoreg;
  logic       memread;
  logic       memwrite;
  logic       regwrite;
  logic [2:0] state;

  modport master (
    output inst_addr, input inst_data,
    output read_register1, output read_register2, output destination_register,
    output imm_ext, output regdst, output alusrc, output memtoreg,
    output memread, output memwrite, output regwrite, output state
  );

  modport slave (
    input inst_addr, output inst_data,
    input read_register1, input read_register2, input destination_register,
    input imm_ext, input regdst, input alusrc, input memtoreg,
    input memread, input memwrite, input regwrite, input state
  );
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decode into level controls and opcode class flags.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [1:0] i_op,
  output logic       o_regdst,
  output logic       o_alusrc,
  output logic       o_memtoreg,
  output logic       o_is_lw,
  output logic       o_is_sw,
  output logic       o_is_j
);

  always_comb begin
    o_regdst   = 1'b0;
    o_alusrc   = 1'b0;
    o_memtoreg = 1'b0;
    o_is_lw    = 1'b0;
    o_is_sw    = 1'b0;
    o_is_j     = 1'b0;
    case (i_op)
      OP_ADD: o_regdst = 1'b1;
      OP_LW: begin
        o_alusrc   = 1'b1;
        o_memtoreg = 1'b1;
        o_is_lw    = 1'b1;
      end
      OP_SW: begin
        o_alusrc = 1'b1;
        o_is_sw  = 1'b1;
      end
      default: o_is_j = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_control.sv
// Multi-cycle fetch/control stage: PC, IR and the IF/ID/EX/MEM/WB sequencer.
// Define FC_SINGLE_STEP_EN to add the `step` port and hold the FSM in IF until a step pulse.
module fetch_control
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic CLK,
  input  logic RESET,
`ifdef FC_SINGLE_STEP_EN
  input  logic step,
`endif
  fetch_control_if.master bus
);

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic       r_regwrite;
  logic       r_memread;
  logic       r_memwrite;

  logic w_regdst;
  logic w_alusrc;
  logic w_memtoreg;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_j;
  logic w_fetch_go;
  logic w_ctl_valid;

`ifdef FC_SINGLE_STEP_EN
  assign w_fetch_go = step;
`else
  assign w_fetch_go = 1'b1;
`endif

  ctrl_decode u_decode (
    .i_op       (r_ir[OP_HI:OP_LO]),
    .o_regdst   (w_regdst),
    .o_alusrc   (w_alusrc),
    .o_memtoreg (w_memtoreg),
    .o_is_lw    (w_is_lw),
    .o_is_sw    (w_is_sw),
    .o_is_j     (w_is_j)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_IF;
      r_pc       <= RESET_PC;
      r_ir       <= 8'h00;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else begin
      case (r_state)
        ST_IF: begin
          if (w_fetch_go) begin
            r_ir    <= bus.inst_data;
            r_pc    <= r_pc + 8'd1;
            r_state <= ST_ID;
          end
        end
        ST_ID: begin
          // Jump offset is relative to the already-incremented PC
          if (w_is_j) begin
            r_pc    <= r_pc + sext_joff(r_ir);
            r_state <= ST_IF;
          end else begin
            r_state <= ST_EX;
          end
        end
        ST_EX: begin
          if (w_is_lw || w_is_sw) begin
            r_memread  <= w_is_lw;
            r_memwrite <= w_is_sw;
            r_state    <= ST_MEM;
          end else begin
            r_regwrite <= 1'b1;
            r_state    <= ST_WB;
          end
        end
        ST_MEM: begin
          r_memread  <= 1'b0;
          r_memwrite <= 1'b0;
          if (w_is_lw) begin
            r_regwrite <= 1'b1;
            r_state    <= ST_WB;
          end else begin
            r_state <= ST_IF;
          end
        end
        ST_WB: begin
          r_regwrite <= 1'b0;
          r_state    <= ST_IF;
        end
        default: begin
          r_regwrite <= 1'b0;
          r_memread  <= 1'b0;
          r_memwrite <= 1'b0;
          r_state    <= ST_IF;
        end
      endcase
    end
  end

  // IR still holds the previous instruction during IF, so controls are masked there
  assign w_ctl_valid = (r_state != ST_IF);

  assign bus.inst_addr            = r_pc;
  assign bus.read_register1       = r_ir[RS_HI:RS_LO];
  assign bus.read_register2       = r_ir[RT_HI:RT_LO];
  assign bus.destination_register = r_ir[RD_HI:RD_LO];
  assign bus.imm_ext              = sext_imm(r_ir);
  assign bus.regdst               = w_regdst & w_ctl_valid;
  assign bus.alusrc               = w_alusrc & w_ctl_valid;
  assign bus.memtoreg             = w_memtoreg & w_ctl_valid;
  assign bus.state                = r_state;

  // A reset landing in MEM or WB must not let the strobe reach the memory or register file
  assign bus.memread  = r_memread & ~RESET;
  assign bus.memwrite = r_memwrite & ~RESET;
  assign bus.regwrite = r_regwrite & ~RESET;

endmodule
